bet_ledger: RTL and testbench

Parametrised successor to the single-player balance maintainer. Tracks a wagering balance across baccarat rounds. Accepts a bet on player, dealer or tie, and locks it for the round. Settles the bet from pscore/dscore when the round ends. Sits beside statemachine/datapath in the top level, clocked by slow_clock, and drives the balance to the LEDR/HEX logic.

---
 rtl/baccarat_pkg.sv | 28 ++
 rtl/bet_payout_calc.sv | 50 +++++
 rtl/bet_ledger.sv | 186 ++++++++++++++++++
 tb/tb_bet_ledger.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared encodings for the baccarat wagering ledger.
//   side_e   : which outcome a bet is placed on
//   result_e : outcome of a finished round
//   state_e  : ledger FSM states
package baccarat_pkg;

   typedef enum logic [1:0] {
      SIDE_NONE   = 2'b00,
      SIDE_PLAYER = 2'b01,
      SIDE_DEALER = 2'b10,
      SIDE_TIE    = 2'b11
   } side_e;

   typedef enum logic [1:0] {
      RES_NONE   = 2'b00,
      RES_PLAYER = 2'b01,
      RES_DEALER = 2'b10,
      RES_TIE    = 2'b11
   } result_e;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StLocked = 2'b01,
      StSettle = 2'b10,
      StBroke  = 2'b11
   } state_e;

endpackage

// File: rtl/bet_payout_calc.sv
// Combinational round outcome and gross payout for one locked bet.
//   side   : side the bet was placed on (side_e encoding)
//   amount : wager
//   pscore : player final score 0..9
//   dscore : dealer final score 0..9
//   result : round outcome (result_e encoding)
//   payout : amount to credit back, BET_W+5 bits wide
module bet_payout_calc
   import baccarat_pkg::*;
#(
   parameter int unsigned BET_W    = 4,
   parameter int unsigned TIE_MULT = 8
) (
   input  logic [1:0]       side,
   input  logic [BET_W-1:0] amount,
   input  logic [3:0]       pscore,
   input  logic [3:0]       dscore,
   output logic [1:0]       result,
   output logic [BET_W+4:0] payout
);

   localparam int unsigned PAY_W = BET_W + 5;

   logic [PAY_W-1:0] amt_ext;

   always_comb begin
      amt_ext = PAY_W'(amount);

      if (pscore > dscore) begin
         result = RES_PLAYER;
      end else if (dscore > pscore) begin
         result = RES_DEALER;
      end else begin
         result = RES_TIE;
      end

      payout = '0;
      if (result == RES_TIE) begin
         if (side == SIDE_TIE) begin
            payout = PAY_W'((TIE_MULT + 1) * amt_ext);
         end else if (side != SIDE_NONE) begin
            // Player/dealer bets are refunded on a tie.
            payout = amt_ext;
         end
      end else if (side == result) begin
         payout = amt_ext << 1;
      end
   end

endmodule

// File: rtl/bet_ledger.sv
// Wagering balance for baccarat rounds: accepts one bet per round, locks it,
// and settles it from the final scores when endround rises.
//   slow_clock   : round clock
//   resetb       : synchronous active-low reset
//   bet_valid    : bet request
//   bet_side     : 00 none, 01 player, 10 dealer, 11 tie
//   bet_amount   : wager
//   endround     : round-complete level
//   pscore       : player final score
//   dscore       : dealer final score
//   balance      : current balance
//   bet_locked   : a bet is held for the current round
//   bet_err      : one-cycle pulse, bet rejected
//   payout_valid : one-cycle pulse, settlement done
//   payout       : amount credited at last settlement
//   last_result  : 01 player, 10 dealer, 11 tie, 00 none yet
//   broke        : balance reached 0, ledger frozen until reset
module bet_ledger
   import baccarat_pkg::*;
#(
   parameter int unsigned BAL_W     = 10,
   parameter int unsigned BET_W     = 4,
   parameter int unsigned START_BAL = 100,
   parameter int unsigned TIE_MULT  = 8
) (
   input  logic             slow_clock,
   input  logic             resetb,
   input  logic             bet_valid,
   input  logic [1:0]       bet_side,
   input  logic [BET_W-1:0] bet_amount,
   input  logic             endround,
   input  logic [3:0]       pscore,
   input  logic [3:0]       dscore,
   output logic [BAL_W-1:0] balance,
   output logic             bet_locked,
   output logic             bet_err,
   output logic             payout_valid,
   output logic [BAL_W-1:0] payout,
   output logic [1:0]       last_result,
   output logic             broke
);

   localparam int unsigned PAY_W = BET_W + 5;
   localparam int unsigned SUM_W = ((BAL_W > PAY_W) ? BAL_W : PAY_W) + 1;
   localparam logic [BAL_W-1:0] BAL_MAX   = '1;
   localparam logic [BAL_W-1:0] BAL_START = BAL_W'(START_BAL);

   if (longint'(START_BAL) > ((longint'(1) << BAL_W) - 1)) begin : g_start_bal_check
      $error("bet_ledger: START_BAL does not fit in BAL_W bits");
   end

   state_e           state_q, state_d;
   logic [BAL_W-1:0] balance_q, balance_d;
   logic [BAL_W-1:0] payout_q, payout_d;
   logic [1:0]       side_q, side_d;
   logic [BET_W-1:0] amount_q, amount_d;
   logic [3:0]       pscore_q, pscore_d;
   logic [3:0]       dscore_q, dscore_d;
   logic [1:0]       last_result_q, last_result_d;
   logic             bet_err_q, bet_err_d;
   logic             payout_valid_q, payout_valid_d;
   logic             endround_q;

   logic             settle_ev;
   logic             bet_ok;
   logic [3:0]       calc_p, calc_d;
   logic [1:0]       calc_result;
   logic [PAY_W-1:0] calc_payout;
   logic [SUM_W-1:0] sum;
   logic [BAL_W-1:0] new_bal;

   // In SETTLE the scores captured at the settle edge are used; otherwise
   // the live scores give the outcome for an unbetted round.
   assign calc_p = (state_q == StSettle) ? pscore_q : pscore;
   assign calc_d = (state_q == StSettle) ? dscore_q : dscore;

   bet_payout_calc #(
      .BET_W    (BET_W),
      .TIE_MULT (TIE_MULT)
   ) u_payout (
      .side   (side_q),
      .amount (amount_q),
      .pscore (calc_p),
      .dscore (calc_d),
      .result (calc_result),
      .payout (calc_payout)
   );

   assign settle_ev = endround & ~endround_q;
   assign bet_ok    = bet_valid && (bet_side != SIDE_NONE) && (bet_amount != '0) &&
                      (SUM_W'(bet_amount) <= SUM_W'(balance_q));

   // Saturating credit; payout reports only what actually landed.
   assign sum     = SUM_W'(balance_q) + SUM_W'(calc_payout);
   assign new_bal = (sum > SUM_W'(BAL_MAX)) ? BAL_MAX : sum[BAL_W-1:0];

   always_comb begin
      state_d        = state_q;
      balance_d      = balance_q;
      payout_d       = payout_q;
      side_d         = side_q;
      amount_d       = amount_q;
      pscore_d       = pscore_q;
      dscore_d       = dscore_q;
      last_result_d  = last_result_q;
      bet_err_d      = 1'b0;
      payout_valid_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (bet_ok) begin
               // A settle on the same edge belongs to the previous round.
               balance_d = balance_q - BAL_W'(bet_amount);
               side_d    = bet_side;
               amount_d  = bet_amount;
               state_d   = StLocked;
            end else begin
               bet_err_d = bet_valid;
               if (settle_ev) begin
                  last_result_d  = calc_result;
                  payout_d       = '0;
                  payout_valid_d = 1'b1;
               end
            end
         end
         StLocked: begin
            if (settle_ev) begin
               pscore_d = pscore;
               dscore_d = dscore;
               state_d  = StSettle;
            end
         end
         StSettle: begin
            balance_d      = new_bal;
            payout_d       = new_bal - balance_q;
            payout_valid_d = 1'b1;
            last_result_d  = calc_result;
            state_d        = (new_bal == '0) ? StBroke : StIdle;
         end
         StBroke: begin
            bet_err_d = bet_valid;
            if (settle_ev) begin
               last_result_d = calc_result;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state_q        <= StIdle;
         balance_q      <= BAL_START;
         payout_q       <= '0;
         side_q         <= SIDE_NONE;
         amount_q       <= '0;
         pscore_q       <= '0;
         dscore_q       <= '0;
         last_result_q  <= RES_NONE;
         bet_err_q      <= 1'b0;
         payout_valid_q <= 1'b0;
         endround_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         balance_q      <= balance_d;
         payout_q       <= payout_d;
         side_q         <= side_d;
         amount_q       <= amount_d;
         pscore_q       <= pscore_d;
         dscore_q       <= dscore_d;
         last_result_q  <= last_result_d;
         bet_err_q      <= bet_err_d;
         payout_valid_q <= payout_valid_d;
         endround_q     <= endround;
      end
   end

   assign balance      = balance_q;
   assign bet_locked   = (state_q == StLocked) || (state_q == StSettle);
   assign bet_err      = bet_err_q;
   assign payout_valid = payout_valid_q;
   assign payout       = payout_q;
   assign last_result  = last_result_q;
   assign broke        = (state_q == StBroke);

endmodule

// File: tb/tb_bet_ledger.sv
// Directed bench for bet_ledger. Four instances share one stimulus stream:
//   u_a default (BAL_W 10, START_BAL 100), u_b BAL_W 8 / START_BAL 250,
//   u_c START_BAL 6, u_d START_BAL 10.
module tb_bet_ledger;

   logic       slow_clock = 1'b0;
   logic       resetb     = 1'b0;
   logic       bet_valid  = 1'b0;
   logic [1:0] bet_side   = 2'b00;
   logic [3:0] bet_amount = 4'd0;
   logic       endround   = 1'b0;
   logic [3:0] pscore     = 4'd0;
   logic [3:0] dscore     = 4'd0;

   logic [9:0] bal_a, pay_a, bal_c, pay_c, bal_d, pay_d;
   logic [7:0] bal_b, pay_b;
   logic       lck_a, err_a, pv_a, brk_a;
   logic       lck_b, err_b, pv_b, brk_b;
   logic       lck_c, err_c, pv_c, brk_c;
   logic       lck_d, err_d, pv_d, brk_d;
   logic [1:0] res_a, res_b, res_c, res_d;

   int tests = 0;
   int fails = 0;
   int pv_count;

   always #5 slow_clock = ~slow_clock;

   bet_ledger u_a (
      .slow_clock (slow_clock), .resetb (resetb), .bet_valid (bet_valid),
      .bet_side (bet_side), .bet_amount (bet_amount), .endround (endround),
      .pscore (pscore), .dscore (dscore), .balance (bal_a), .bet_locked (lck_a),
      .bet_err (err_a), .payout_valid (pv_a), .payout (pay_a),
      .last_result (res_a), .broke (brk_a)
   );

   bet_ledger #(.BAL_W (8), .START_BAL (250)) u_b (
      .slow_clock (slow_clock), .resetb (resetb), .bet_valid (bet_valid),
      .bet_side (bet_side), .bet_amount (bet_amount), .endround (endround),
      .pscore (pscore), .dscore (dscore), .balance (bal_b), .bet_locked (lck_b),
      .bet_err (err_b), .payout_valid (pv_b), .payout (pay_b),
      .last_result (res_b), .broke (brk_b)
   );

   bet_ledger #(.START_BAL (6)) u_c (
      .slow_clock (slow_clock), .resetb (resetb), .bet_valid (bet_valid),
      .bet_side (bet_side), .bet_amount (bet_amount), .endround (endround),
      .pscore (pscore), .dscore (dscore), .balance (bal_c), .bet_locked (lck_c),
      .bet_err (err_c), .payout_valid (pv_c), .payout (pay_c),
      .last_result (res_c), .broke (brk_c)
   );

   bet_ledger #(.START_BAL (10)) u_d (
      .slow_clock (slow_clock), .resetb (resetb), .bet_valid (bet_valid),
      .bet_side (bet_side), .bet_amount (bet_amount), .endround (endround),
      .pscore (pscore), .dscore (dscore), .balance (bal_d), .bet_locked (lck_d),
      .bet_err (err_d), .payout_valid (pv_d), .payout (pay_d),
      .last_result (res_d), .broke (brk_d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
   endtask

   task automatic bet(input logic [1:0] side, input logic [3:0] amt);
      bet_valid  = 1'b1;
      bet_side   = side;
      bet_amount = amt;
      tick();
      bet_valid  = 1'b0;
   endtask

   task automatic round_end(input logic [3:0] p, input logic [3:0] d);
      pscore   = p;
      dscore   = d;
      endround = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state and player win
      do_reset();
      check("rst_balance", bal_a, 100);
      check("rst_locked", lck_a, 0);
      check("rst_result", res_a, 0);
      check("rst_broke", brk_a, 0);
      check("rst_payout", pay_a, 0);
      check("rst_pv", pv_a, 0);
      check("rst_err", err_a, 0);
      bet(2'b01, 4'd5);
      check("pw_bal_after_bet", bal_a, 95);
      check("pw_locked", lck_a, 1);
      round_end(4'd7, 4'd3);
      tick();
      check("pw_pv_latency", pv_a, 0);
      check("pw_bal_latency", bal_a, 95);
      tick();
      check("pw_balance", bal_a, 105);
      check("pw_payout", pay_a, 10);
      check("pw_result", res_a, 1);
      check("pw_pv", pv_a, 1);
      check("pw_unlocked", lck_a, 0);
      tick();
      check("pw_pv_pulse", pv_a, 0);
      endround = 1'b0;
      tick();

      // Tie bet win
      do_reset();
      bet(2'b11, 4'd4);
      check("tie_bal_after_bet", bal_a, 96);
      round_end(4'd6, 4'd6);
      tick();
      tick();
      check("tie_balance", bal_a, 132);
      check("tie_payout", pay_a, 36);
      check("tie_result", res_a, 3);
      endround = 1'b0;
      tick();

      // Push refund with endround held high
      do_reset();
      bet(2'b01, 4'd3);
      check("push_bal_after_bet", bal_a, 97);
      round_end(4'd5, 4'd5);
      pv_count = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pv_count += int'(pv_a);
      end
      check("push_pv_once", pv_count, 1);
      check("push_balance", bal_a, 100);
      check("push_payout", pay_a, 3);
      endround = 1'b0;
      tick();

      // Rejected bets (u_d starts at 10)
      do_reset();
      check("ob_rst_bal", bal_d, 10);
      bet(2'b01, 4'd15);
      check("ob_err", err_d, 1);
      check("ob_bal", bal_d, 10);
      check("ob_unlocked", lck_d, 0);
      tick();
      check("ob_err_pulse", err_d, 0);
      bet(2'b00, 4'd3);
      check("noside_err", err_d, 1);
      bet(2'b01, 4'd0);
      check("zero_amt_err", err_d, 1);
      bet(2'b01, 4'd3);
      check("ok_err", err_d, 0);
      check("ok_bal", bal_d, 7);
      check("ok_locked", lck_d, 1);
      bet(2'b10, 4'd2);
      check("locked_ignore_err", err_d, 0);
      check("locked_ignore_bal", bal_d, 7);
      check("locked_ignore_lck", lck_d, 1);

      // Saturation (u_b: BAL_W 8, start 250)
      do_reset();
      check("sat_rst_bal", bal_b, 250);
      bet(2'b11, 4'd10);
      check("sat_bal_after_bet", bal_b, 240);
      round_end(4'd4, 4'd4);
      tick();
      tick();
      check("sat_balance", bal_b, 255);
      check("sat_payout", pay_b, 15);
      check("sat_result", res_b, 3);
      endround = 1'b0;
      tick();

      // Broke (u_c: start 6); u_a follows the same stream
      do_reset();
      bet(2'b10, 4'd6);
      check("brk_bal_after_bet", bal_c, 0);
      check("brk_locked", lck_c, 1);
      round_end(4'd9, 4'd1);
      tick();
      check("brk_not_yet", brk_c, 0);
      tick();
      check("brk_balance", bal_c, 0);
      check("brk_payout", pay_c, 0);
      check("brk_pv", pv_c, 1);
      check("brk_result", res_c, 1);
      check("brk_flag", brk_c, 1);
      check("brk_a_balance", bal_a, 94);
      endround = 1'b0;
      tick();
      bet(2'b01, 4'd1);
      check("brk_bet_err", err_c, 1);
      check("brk_still", brk_c, 1);
      check("brk_bal_frozen", bal_c, 0);
      check("brk_a_accepts", bal_a, 93);
      round_end(4'd1, 4'd2);
      tick();
      check("brk_settle_result", res_c, 2);
      endround = 1'b0;
      tick();
      check("brk_a_result", res_a, 2);
      check("brk_a_bal", bal_a, 93);

      // Reset while a bet is locked
      bet(2'b01, 4'd5);
      check("mid_bal_locked", bal_a, 88);
      check("mid_locked", lck_a, 1);
      do_reset();
      check("mid_rst_bal", bal_a, 100);
      check("mid_rst_locked", lck_a, 0);
      check("mid_rst_result", res_a, 0);
      check("mid_rst_broke_c", brk_c, 0);
      check("mid_rst_bal_c", bal_c, 6);

      // Bet and settle on the same edge: bet wins, settle dropped
      pscore     = 4'd3;
      dscore     = 4'd1;
      endround   = 1'b1;
      bet(2'b01, 4'd2);
      check("same_edge_bal", bal_a, 98);
      check("same_edge_locked", lck_a, 1);
      check("same_edge_pv", pv_a, 0);
      tick();
      check("same_edge_hold_locked", lck_a, 1);
      check("same_edge_hold_pv", pv_a, 0);
      endround = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
